regfile32x32: RTL and testbench



---
 rtl/regfile32x32_pkg.sv | 13 +
 rtl/decoder5to32.sv | 15 +
 rtl/regfile32x32.sv | 78 +++++++
 tb/tb_regfile32x32.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile32x32_pkg.sv
// Shared definitions for the 32x32 register file: data and index widths,
// the hardwired-zero register index and the matching typedefs.
package regfile32x32_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_IDX_W  = 5;

  localparam logic [REGFILE_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REGFILE_IDX_W-1:0]  reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0] data_t;

endpackage

// File: rtl/decoder5to32.sv
// Write-address decoder: turns a 5-bit register index into 32 one-hot lines.
module decoder5to32
  import regfile32x32_pkg::*;
(
  input  reg_idx_t    S,
  output logic [31:0] m
);

  // Exactly one output line is raised, the one selected by S.
  always_comb begin
    m    = '0;
    m[S] = 1'b1;
  end

endmodule

// File: rtl/regfile32x32.sv
// 32-entry x DATA_W register file, two asynchronous read ports, one write port.
// r0 is hardwired to zero. Optional macro REGFILE_BYPASS_EN makes the read ports
// forward the write data in the same cycle (write-first); without it reads
// return the stored value until the write edge (read-before-write).
module regfile32x32
  import regfile32x32_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr1,
  input  reg_idx_t          raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [NREGS-1:0]  dec_lines;
  logic [NREGS-1:0]  en;
  logic [DATA_W-1:0] regs [NREGS];

  decoder5to32 u_wdec (
    .S (waddr),
    .m (dec_lines)
  );

  // Gate each one-hot line with we; r0 can never be enabled.
  always_comb begin
    en    = dec_lines & {NREGS{we}};
    en[0] = 1'b0;
  end

  // Storage: async clear has priority, otherwise the single enabled register loads wdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NREGS; k++) begin
        if (en[k]) begin
          regs[k] <= wdata;
        end
      end
    end
  end

  // Read port 1: index 0 always reads zero; optional same-cycle forwarding of wdata.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != REG_ZERO) begin
      rdata1 = regs[raddr1];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we && (waddr != REG_ZERO) && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
`endif
  end

  // Read port 2: same behaviour as port 1, fully independent of it.
  always_comb begin
    rdata2 = '0;
    if (raddr2 != REG_ZERO) begin
      rdata2 = regs[raddr2];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we && (waddr != REG_ZERO) && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule

// File: tb/tb_regfile32x32.sv
// Scoreboard testbench for regfile32x32: stimulus pushes expected read data
// computed from a plain array model, a negedge monitor pops and compares.
module tb_regfile32x32;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  logic        chk_valid;
  sb_entry_t   sb[$];
  logic [31:0] model [32];
  int          total;
  int          bad;

  regfile32x32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // What a read of index a should return right now, from the register file's rules
  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 5'd0 && a == waddr) return wdata;
`endif
    return model[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  // rst_mid drops rst_n partway through the cycle, before the outputs are sampled.
  task automatic applyStimulus(input string name, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2, input logic check, input logic rst_mid);
    sb_entry_t e;
    we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    if (rst_mid) begin
      #2;
      rst_n = 1'b0;
      clearModel();
    end
    if (check) begin
      e.name = name;
      e.exp1 = expRead(a1);
      e.exp2 = expRead(a2);
      sb.push_back(e);
    end
    chk_valid = check;
    @(posedge clk);
    if (rst_n && w && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  task automatic readAll(input string name);
    for (int k = 0; k < 32; k++)
      applyStimulus(name, 1'b0, 5'(k), $urandom, 5'(k), 5'(31 - k), 1'b1, 1'b0);
  endtask

  task automatic fillSweep();
    for (int k = 1; k < 32; k++)
      applyStimulus("sweep_wr", 1'b1, 5'(k), 32'hA500_0000 + 32'(k),
                    5'($urandom_range(0, 31)), 5'(k), 1'b1, 1'b0);
  endtask

  // Monitor: whenever the stimulus flags a sample, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_rd1"}, rdata1, e.exp1);
        checkOutput({e.name, "_rd2"}, rdata2, e.exp2);
      end
    end
  end

  initial begin
    total = 0; bad = 0; chk_valid = 1'b0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    clearModel();
    @(posedge clk);
    #1;

    // Reset held: writes are ignored and every index reads zero on both ports
    for (int k = 0; k < 32; k++)
      applyStimulus("reset_read", 1'b1, 5'($urandom_range(1, 31)), $urandom,
                    5'(k), 5'(31 - k), 1'b1, 1'b0);

    // First write after release, then read it back
    rst_n = 1'b1;
    applyStimulus("r5_write", 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0, 1'b1, 1'b0);
    applyStimulus("r5_read", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b0);

    // Full sweep then read everything back
    fillSweep();
    readAll("sweep_rd");

    // r0 protection
    applyStimulus("r0_write", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd1, 1'b1, 1'b0);
    readAll("r0_after");

    // Read-during-write on r7
    applyStimulus("r7_init", 1'b1, 5'd7, 32'h1111_1111, 5'd3, 5'd4, 1'b1, 1'b0);
    applyStimulus("r7_rdw", 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 1'b1, 1'b0);
    applyStimulus("r7_after", 1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      applyStimulus("random", 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b0);

    // we=0 hold: inputs wiggle, nothing changes
    for (int i = 0; i < 10; i++)
      applyStimulus("we0_hold", 1'b0, 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    readAll("we0_after");

    // Async reset mid-cycle with a pending write to r9
    fillSweep();
    applyStimulus("rst_mid", 1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd20, 1'b1, 1'b1);
    applyStimulus("rst_held", 1'b0, 5'd9, 32'h0, 5'd9, 5'd31, 1'b1, 1'b0);
    rst_n = 1'b1;
    readAll("rst_after");

    chk_valid = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
